decode_stage: RTL

- Registered, pipelined Octa16 instruction decode stage with valid/ready handshake on both sides.
- Accepts a 16-bit instruction plus its PC from fetch and emits fully decoded fields to execute: register indices with enables, sign-extended immediate, write-enable and illegal-instruction flag.
- A 2-entry output buffer gives full throughput under backpressure. A flush input supports branch redirect.
- Immediates are generalised to XLEN bits, and an illegal-instruction counter is added.

---
 rtl/decode_stage.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Octa16 decode stage: combinational decode of the fetched instruction,
// a 2-entry output FIFO with a registered in_ready, flush support for branch
// redirect, and a saturating count of illegal instructions delivered downstream.
module decode_stage #(
    parameter int XLEN  = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [2:0]       out_opcode,
    output logic [2:0]       out_func,
    output logic [2:0]       out_rs1,
    output logic [2:0]       out_rs2,
    output logic [2:0]       out_rd,
    output logic             out_rs1_en,
    output logic             out_rs2_en,
    output logic             out_rd_we,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] OP_R = 3'b000;
    localparam logic [2:0] OP_I = 3'b001;
    localparam logic [2:0] OP_L = 3'b010;
    localparam logic [2:0] OP_S = 3'b011;
    localparam logic [2:0] OP_B = 3'b100;
    localparam logic [2:0] OP_J = 3'b101;
    localparam logic [2:0] OP_P = 3'b110;

    localparam logic [2:0] FN_JAL   = 3'b000;
    localparam logic [2:0] FN_JALR  = 3'b100;
    localparam logic [2:0] FN_AUIR  = 3'b000;
    localparam logic [2:0] FN_ADDPC = 3'b001;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [2:0]      opcode;
        logic [2:0]      func;
        logic [2:0]      rs1;
        logic [2:0]      rs2;
        logic [2:0]      rd;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_we;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    // Sign-extend a 4-bit immediate to the datapath width.
    function automatic logic [XLEN-1:0] sext4(input logic [3:0] v);
        return {{(XLEN-4){v[3]}}, v};
    endfunction

    // Sign-extend a 7-bit immediate to the datapath width.
    function automatic logic [XLEN-1:0] sext7(input logic [6:0] v);
        return {{(XLEN-7){v[6]}}, v};
    endfunction

    logic [2:0]       op_s;
    logic [2:0]       func_s;
    logic [2:0]       rs1_f_s;
    logic [2:0]       rd_f_s;
    logic [2:0]       rs2_f_s;
    entry_t           dec_s;
    entry_t           head_s;
    entry_t           mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic [1:0]       count_next_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] illegal_cnt_r;

    assign op_s    = in_inst[2:0];
    assign func_s  = in_inst[5:3];
    assign rd_f_s  = in_inst[8:6];
    assign rs1_f_s = in_inst[11:9];
    assign rs2_f_s = in_inst[14:12];

    // Decode the incoming instruction word into its execute-side fields.
    always_comb begin
        dec_s        = '0;
        dec_s.pc     = in_pc;
        dec_s.opcode = op_s;
        case (op_s)
            OP_R: begin
                dec_s.rs1    = rs1_f_s;
                dec_s.rs2    = rs2_f_s;
                dec_s.rd     = rd_f_s;
                dec_s.func   = func_s;
                dec_s.rs1_en = 1'b1;
                dec_s.rs2_en = 1'b1;
                dec_s.rd_we  = 1'b1;
            end
            OP_I: begin
                dec_s.rs1    = rs1_f_s;
                dec_s.rd     = rd_f_s;
                dec_s.func   = func_s;
                dec_s.rs1_en = 1'b1;
                dec_s.rd_we  = 1'b1;
                dec_s.imm    = sext4(in_inst[15:12]);
            end
            OP_L: begin
                dec_s.rs1    = rs1_f_s;
                dec_s.rd     = rd_f_s;
                dec_s.rs1_en = 1'b1;
                dec_s.rd_we  = 1'b1;
                dec_s.imm    = sext7({in_inst[15:12], in_inst[5:3]});
            end
            OP_S: begin
                // Store data register sits in the rd slot of the encoding.
                dec_s.rs1    = rs1_f_s;
                dec_s.rs2    = rd_f_s;
                dec_s.rs1_en = 1'b1;
                dec_s.rs2_en = 1'b1;
                dec_s.imm    = sext7({in_inst[15:12], in_inst[5:3]});
            end
            OP_B: begin
                dec_s.rs1    = rs1_f_s;
                dec_s.rs2    = rs2_f_s;
                dec_s.func   = func_s;
                dec_s.rs1_en = 1'b1;
                dec_s.rs2_en = 1'b1;
                dec_s.imm    = sext4({in_inst[15], in_inst[8:6]});
            end
            OP_J: begin
                dec_s.func = func_s;
                if (func_s == FN_JAL) begin
                    dec_s.rd    = rd_f_s;
                    dec_s.rd_we = 1'b1;
                    dec_s.imm   = sext7(in_inst[15:9]);
                end else if (func_s == FN_JALR) begin
                    dec_s.rd     = rd_f_s;
                    dec_s.rs1    = rs1_f_s;
                    dec_s.rs1_en = 1'b1;
                    dec_s.rd_we  = 1'b1;
                    dec_s.imm    = sext4(in_inst[15:12]);
                end else begin
                    dec_s.illegal = 1'b1;
                end
            end
            OP_P: begin
                dec_s.func = func_s;
                if (func_s == FN_ADDPC) begin
                    dec_s.rd    = rd_f_s;
                    dec_s.rd_we = 1'b1;
                    dec_s.imm   = sext7(in_inst[15:9]);
                end else if (func_s == FN_AUIR) begin
                    dec_s.rd     = rd_f_s;
                    dec_s.rs1    = rs1_f_s;
                    dec_s.rs1_en = 1'b1;
                    dec_s.rd_we  = 1'b1;
                    dec_s.imm    = sext4(in_inst[15:12]);
                end else begin
                    dec_s.illegal = 1'b1;
                end
            end
            default: begin
                dec_s.func    = func_s;
                dec_s.illegal = 1'b1;
            end
        endcase
    end

    // An incoming instruction in a flush cycle belongs to the squashed path.
    assign push_s = in_valid && in_ready_r && !flush;
    assign pop_s  = out_valid_r && out_ready;
    assign head_s = mem_r[rd_ptr_r];

    // Next occupancy: flush empties the buffer, push/pop move it by one.
    always_comb begin
        count_next_s = count_r;
        if (flush) begin
            count_next_s = 2'd0;
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + 2'd1;
        end else if (!push_s && pop_s) begin
            count_next_s = count_r - 2'd1;
        end else begin
            count_next_s = count_r;
        end
    end

    // Entry storage: write the decoded instruction at the tail on a push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= dec_s;
        end
    end

    // Pointers, occupancy and the registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            count_r     <= 2'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_r <= 1'b0;
                rd_ptr_r <= 1'b0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + 1'b1;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + 1'b1;
                end
            end
            count_r     <= count_next_s;
            in_ready_r  <= (count_next_s != 2'd2);
            out_valid_r <= (count_next_s != 2'd0);
        end
    end

    // Saturating count of illegal instructions handed to execute.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt_r <= '0;
        end else if (pop_s && head_s.illegal && (illegal_cnt_r != CNT_MAX)) begin
            illegal_cnt_r <= illegal_cnt_r + CNT_ONE;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_pc      = head_s.pc;
    assign out_opcode  = head_s.opcode;
    assign out_func    = head_s.func;
    assign out_rs1     = head_s.rs1;
    assign out_rs2     = head_s.rs2;
    assign out_rd      = head_s.rd;
    assign out_rs1_en  = head_s.rs1_en;
    assign out_rs2_en  = head_s.rs2_en;
    assign out_rd_we   = head_s.rd_we;
    assign out_imm     = head_s.imm;
    assign out_illegal = head_s.illegal;
    assign illegal_cnt = illegal_cnt_r;

    decode_stage_checker #(
        .W($bits(entry_t))
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_ready  (in_ready_r),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .count     (count_r),
        .illegal   (head_s.illegal),
        .enables   ({head_s.rs1_en, head_s.rs2_en, head_s.rd_we}),
        .payload   (head_s)
    );

endmodule

// Structural invariants of the decode stage buffer and handshake.
module decode_stage_checker #(
    parameter int W = 8
) (
    input logic         clk,
    input logic         rst,
    input logic         flush,
    input logic         in_ready,
    input logic         out_valid,
    input logic         out_ready,
    input logic [1:0]   count,
    input logic         illegal,
    input logic [2:0]   enables,
    input logic [W-1:0] payload
);

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count != 2'd3);

    a_valid_matches_count: assert property (@(posedge clk) disable iff (rst)
        out_valid == (count != 2'd0));

    a_full_blocks_input: assert property (@(posedge clk) disable iff (rst)
        (count == 2'd2) |-> !in_ready);

    a_hold_when_stalled: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(payload)));

    a_illegal_no_enables: assert property (@(posedge clk) disable iff (rst)
        (out_valid && illegal) |-> (enables == 3'b000));

endmodule
